// File: rtl/mem_port_sched_if.sv
// mem_port_sched_if: groups the load/store port, the return-address stack port,
// the data-memory port and the status/error flags of mem_port_sched.
//   slave  : the scheduler side (takes requests, drives memory and status)
//   master : the requester / memory side (drives requests and mem_rdata)
// Widths: ls_addr/mem_addr 8 bits, all data 32 bits, everything else 1 bit.
interface mem_port_sched_if;
  // Load/store requester
  logic        ls_req;
  logic        ls_we;
  logic [7:0]  ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  // CALL/RET stack requester
  logic        stk_push;
  logic        stk_pop;
  logic [31:0] stk_wdata;
  logic        stk_gnt;
  logic        ret_valid;
  logic [31:0] ret_pc;
  // Data memory
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  // Status and sticky errors
  logic        stk_empty;
  logic        stk_full;
  logic        busy;
  logic        ovf_err;
  logic        unf_err;
  logic        prot_err;

  modport slave (
    input  ls_req, ls_we, ls_addr, ls_wdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    input  stk_push, stk_pop, stk_wdata,
    output stk_gnt, ret_valid, ret_pc,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output stk_empty, stk_full, busy, ovf_err, unf_err, prot_err
  );

  modport master (
    output ls_req, ls_we, ls_addr, ls_wdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    output stk_push, stk_pop, stk_wdata,
    input  stk_gnt, ret_valid, ret_pc,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  stk_empty, stk_full, busy, ovf_err, unf_err, prot_err
  );
endinterface

// File: rtl/mem_port_sched.sv
// mem_port_sched: shares one single-port data memory between the load/store
// unit and a return-address stack kept in memory at STK_BASE..STK_BASE+STK_DEPTH-1.
// Stack requests (pop over push) win over load/store unless the load/store
// request has been passed over STARVE_MAX times, in which case it wins once.
// All outputs are registered: a request seen in IDLE produces its grant and the
// memory access in the following cycle; mem_rdata is expected valid during that
// access cycle and is returned (ls_rvalid / ret_valid) one cycle later.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-high reset
//   bus   : mem_port_sched_if.slave (request ports, memory port, status flags)
module mem_port_sched #(
  parameter int unsigned STK_DEPTH  = 16,
  parameter logic [7:0]  STK_BASE   = 8'hF0,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_port_sched_if.slave       bus
);

  localparam int unsigned TOP_W = $clog2(STK_DEPTH + 1);
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic {IDLE, RD_WAIT} state_e;

  state_e             state_q, state_d;
  logic [TOP_W-1:0]   top_q, top_d;
  logic [CNT_W-1:0]   starve_q, starve_d;
  logic               rd_stk_q;   // outstanding read belongs to a pop
  logic               rd_zero_q;  // outstanding read is a blocked load, return 0

  logic               ls_gnt_q, ls_rvalid_q, stk_gnt_q, ret_valid_q;
  logic [31:0]        ls_rdata_q, ret_pc_q;
  logic               mem_en_q, mem_we_q;
  logic [7:0]         mem_addr_q;
  logic [31:0]        mem_wdata_q;
  logic               stk_empty_q, stk_full_q, busy_q;
  logic               ovf_q, unf_q, prot_q;

  logic               idle_c, empty_c, full_c, ls_force_c, ls_prot_c;
  logic               sel_ls_c, sel_pop_c, sel_push_c;

  // Arbitration and next-state values
  always_comb begin
    idle_c     = (state_q == IDLE);
    empty_c    = (top_q == '0);
    full_c     = (top_q == TOP_W'(STK_DEPTH));
    ls_force_c = (starve_q == CNT_W'(STARVE_MAX));
    ls_prot_c  = (32'(bus.ls_addr) >= 32'(STK_BASE)) &&
                 (32'(bus.ls_addr) <  32'(STK_BASE) + STK_DEPTH);
    sel_ls_c   = idle_c && bus.ls_req &&
                 (ls_force_c || !(bus.stk_pop || bus.stk_push));
    sel_pop_c  = idle_c && bus.stk_pop && !sel_ls_c;
    sel_push_c = idle_c && bus.stk_push && !bus.stk_pop && !sel_ls_c;

    top_d = top_q;
    if (sel_pop_c && !empty_c) begin
      top_d = top_q - TOP_W'(1);
    end else if (sel_push_c && !full_c) begin
      top_d = top_q + TOP_W'(1);
    end

    // Blocked loads still pass through RD_WAIT so the requester sees ls_rvalid.
    state_d = IDLE;
    if ((sel_pop_c && !empty_c) || (sel_ls_c && !bus.ls_we)) begin
      state_d = RD_WAIT;
    end

    starve_d = starve_q;
    if (sel_ls_c) begin
      starve_d = '0;
    end else if (idle_c && bus.ls_req && !ls_force_c) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // Scheduler FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      top_q       <= '0;
      starve_q    <= '0;
      rd_stk_q    <= 1'b0;
      rd_zero_q   <= 1'b0;
      ls_gnt_q    <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= '0;
      stk_gnt_q   <= 1'b0;
      ret_valid_q <= 1'b0;
      ret_pc_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      stk_empty_q <= 1'b1;
      stk_full_q  <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      prot_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      top_q       <= top_d;
      starve_q    <= starve_d;
      stk_empty_q <= (top_d == '0);
      stk_full_q  <= (top_d == TOP_W'(STK_DEPTH));
      busy_q      <= (state_d != IDLE);

      // Pulses and memory port default to idle every cycle
      ls_gnt_q    <= 1'b0;
      ls_rvalid_q <= 1'b0;
      stk_gnt_q   <= 1'b0;
      ret_valid_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;

      unique case (state_q)
        IDLE: begin
          if (sel_pop_c) begin
            stk_gnt_q <= 1'b1;
            if (empty_c) begin
              unf_q <= 1'b1;
            end else begin
              mem_en_q   <= 1'b1;
              mem_addr_q <= STK_BASE + 8'(top_q) - 8'd1;
              rd_stk_q   <= 1'b1;
              rd_zero_q  <= 1'b0;
            end
          end else if (sel_push_c) begin
            stk_gnt_q <= 1'b1;
            if (full_c) begin
              ovf_q <= 1'b1;
            end else begin
              mem_en_q    <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= STK_BASE + 8'(top_q);
              mem_wdata_q <= bus.stk_wdata;
            end
          end else if (sel_ls_c) begin
            ls_gnt_q  <= 1'b1;
            rd_stk_q  <= 1'b0;
            rd_zero_q <= ls_prot_c;
            if (ls_prot_c) begin
              prot_q <= 1'b1;
            end else begin
              mem_en_q    <= 1'b1;
              mem_we_q    <= bus.ls_we;
              mem_addr_q  <= bus.ls_addr;
              mem_wdata_q <= bus.ls_we ? bus.ls_wdata : 32'd0;
            end
          end
        end
        RD_WAIT: begin
          if (rd_stk_q) begin
            ret_valid_q <= 1'b1;
            ret_pc_q    <= bus.mem_rdata;
          end else begin
            ls_rvalid_q <= 1'b1;
            ls_rdata_q  <= rd_zero_q ? 32'd0 : bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ls_gnt    = ls_gnt_q;
  assign bus.ls_rvalid = ls_rvalid_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.stk_gnt   = stk_gnt_q;
  assign bus.ret_valid = ret_valid_q;
  assign bus.ret_pc    = ret_pc_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.stk_empty = stk_empty_q;
  assign bus.stk_full  = stk_full_q;
  assign bus.busy      = busy_q;
  assign bus.ovf_err   = ovf_q;
  assign bus.unf_err   = unf_q;
  assign bus.prot_err  = prot_q;

endmodule

// File: doc/mem_port_sched.md
MEM_PORT_SCHED -- requirements
Module: mem_port_sched

Interface
REQ-001 Parameter: STK_DEPTH, 16, return-address stack entries held in data memory.
REQ-002 Parameter: STK_BASE, 8'hF0, data-memory word address of stack entry 0; stack occupies STK_BASE..STK_BASE+STK_DEPTH-1.
REQ-003 Parameter: STARVE_MAX, 4, consecutive cycles a pending LS request may be passed over before it gets forced priority.
REQ-004 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: ls_req  in  1  load/store request; held until ls_gnt.
REQ-007 Port: ls_we  in  1  1=store, 0=load; stable while ls_req high.
REQ-008 Port: ls_addr  in  8  load/store word address (ALU result, low 8 bits).
REQ-009 Port: ls_wdata  in  32  store data (Rd).
REQ-010 Port: ls_gnt  out  1  one-cycle pulse; request accepted.
REQ-011 Port: ls_rvalid  out  1  one-cycle pulse; ls_rdata valid.
REQ-012 Port: ls_rdata  out  32  load data.
REQ-013 Port: stk_push  in  1  CALL: push stk_wdata; held until stk_gnt.
REQ-014 Port: stk_pop  in  1  RET: pop return PC; held until stk_gnt.
REQ-015 Port: stk_wdata  in  32  return PC to push.
REQ-016 Port: stk_gnt  out  1  one-cycle pulse; push/pop accepted.
REQ-017 Port: ret_valid  out  1  one-cycle pulse; ret_pc valid.
REQ-018 Port: ret_pc  out  32  popped return address.
REQ-019 Port: mem_en, mem_we  out  1 each  data-memory port enable / write enable.
REQ-020 Port: mem_addr  out  8; mem_wdata  out  32; mem_rdata  in  32 (valid the cycle after a read issue).
REQ-021 Port: stk_empty, stk_full  out  1 each  top==0 / top==STK_DEPTH.
REQ-022 Port: busy  out  1  FSM not in IDLE.
REQ-023 Port: ovf_err, unf_err, prot_err  out  1 each  sticky error flags.

Function
REQ-024 FSM states IDLE, RD_WAIT; at most one memory access issued per cycle, one read outstanding.
REQ-025 IDLE: arbitrate; issuing any read -> RD_WAIT; writes, dropped requests and no request -> stay IDLE.
REQ-026 RD_WAIT: no grants, mem_en=0; next cycle -> IDLE and pulse ls_rvalid or ret_valid with data = mem_rdata.
REQ-027 Priority in IDLE: stack (pop over push) over LS, unless starve counter == STARVE_MAX, then LS wins that cycle.
REQ-028 Starve counter: increments each IDLE cycle ls_req is high without ls_gnt, saturates at STARVE_MAX, clears on ls_gnt.
REQ-029 Simultaneous push and pop: pop granted; push stays pending and is arbitrated on a later IDLE cycle.
REQ-030 Push, not full: mem_we=1, mem_addr=STK_BASE+top, mem_wdata=stk_wdata, top<=top+1, stk_gnt pulse.
REQ-031 Push, full: stk_gnt pulse, no memory access, top unchanged, ovf_err<=1.
REQ-032 Pop, not empty: read at STK_BASE+top-1, top<=top-1, stk_gnt pulse, ret_valid 2 cycles after request accepted edge (one after issue).
REQ-033 Pop, empty: stk_gnt pulse, no access, no ret_valid, unf_err<=1.
REQ-034 LS with ls_addr in stack region: ls_gnt pulse, no access, prot_err<=1; load returns ls_rvalid next cycle with ls_rdata=0 (via RD_WAIT).
REQ-035 LS legal: store writes ls_wdata at ls_addr (1 cycle); load reads ls_addr, ls_rvalid one cycle after ls_gnt.
REQ-036 ls_rdata/ret_pc hold last value between valid pulses; mem_* outputs zero when mem_en=0.
REQ-037 Error flags are sticky until reset.

Reset
REQ-038 reset high at clk edge: state IDLE, top=0, starve counter=0, all outputs 0 (stk_empty=1), error flags 0.
REQ-039 Reset during RD_WAIT cancels the read: no ls_rvalid/ret_valid after reset.

Verification
REQ-040 Push 0x100, 0x200, then pop twice -> writes at 0xF0,0xF1; ret_pc 0x200 then 0x100; stk_empty=1 at end.
REQ-041 17 pushes -> 17th: stk_gnt, no mem_en, ovf_err=1, stk_full stays 1; pop on empty after reset -> unf_err=1, no ret_valid.
REQ-042 Store 0xDEADBEEF to 0x10, load 0x10 -> ls_rvalid one cycle after ls_gnt with 0xDEADBEEF.
REQ-043 ls_req held with stk_push each cycle -> ls_gnt by 5th cycle of waiting (STARVE_MAX=4).
REQ-044 Load from 0xF3 -> prot_err=1, ls_rdata=0, no mem_en; assert reset in RD_WAIT of a pop -> no ret_valid, top=0.
